// File: rtl/spmv_mem_arbiter.sv
// Two-requester arbiter and whole-memory zero-clear sequencer for a single-port, synchronous-read vector memory.
// Build option: define SPMV_MEM_ARB_FIXED_PRIO_EN to make requester 0 always win contention (no round-robin pointer).
module spmv_mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int SIZE = 16,
  localparam int ADDR_BITS = $clog2(SIZE - 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_op,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [WIDTH-1:0]     req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_op,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [WIDTH-1:0]     req1_wdata,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [WIDTH-1:0]     rsp_rdata,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_data_in,
  output logic                 mem_data_op,
  input  logic [WIDTH-1:0]     mem_data_out
);

  typedef enum logic {ST_SERVE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SIZE - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_BITS-1:0]   r_clr_addr;
  logic [ADDR_BITS-1:0]   w_clr_addr_nxt;
  logic                   r_clear_done;
  logic                   w_clear_done_nxt;
  logic                   r_rd_valid;
  logic                   r_rd_id;
  logic                   w_grant0;
  logic                   w_grant1;
  logic                   w_prio;

`ifdef SPMV_MEM_ARB_FIXED_PRIO_EN
  assign w_prio = 1'b0;
`else
  logic r_prio;
  assign w_prio = r_prio;

  // Round-robin pointer: after a contended grant the loser gets priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_grant0 && req1_valid) begin
      r_prio <= 1'b1;
    end else if (w_grant1 && req0_valid) begin
      r_prio <= 1'b0;
    end else begin
      r_prio <= r_prio;
    end
  end
`endif

  // Next-state, grant and memory-port steering.
  always_comb begin
    w_state_nxt      = r_state;
    w_clr_addr_nxt   = r_clr_addr;
    w_clear_done_nxt = 1'b0;
    w_grant0         = 1'b0;
    w_grant1         = 1'b0;
    mem_addr         = '0;
    mem_data_in      = '0;
    mem_data_op      = 1'b0;
    case (r_state)
      ST_SERVE: begin
        if (clear_req) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_addr_nxt = '0;
        end else if (req0_valid && (!req1_valid || !w_prio)) begin
          w_grant0 = 1'b1;
        end else if (req1_valid) begin
          w_grant1 = 1'b1;
        end else begin
          w_grant0 = 1'b0;
        end
        if (w_grant0) begin
          mem_addr    = req0_addr;
          mem_data_in = req0_wdata;
          mem_data_op = req0_op;
        end else if (w_grant1) begin
          mem_addr    = req1_addr;
          mem_data_in = req1_wdata;
          mem_data_op = req1_op;
        end else begin
          mem_data_op = 1'b0;
        end
      end
      ST_CLEAR: begin
        mem_addr    = r_clr_addr;
        mem_data_op = 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt      = ST_SERVE;
          w_clr_addr_nxt   = '0;
          w_clear_done_nxt = 1'b1;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_BITS'(1);
        end
      end
      default: begin
        w_state_nxt = ST_SERVE;
      end
    endcase
  end

  // State, sweep counter, done pulse and read-response tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SERVE;
      r_clr_addr   <= '0;
      r_clear_done <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_id      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_addr   <= w_clr_addr_nxt;
      r_clear_done <= w_clear_done_nxt;
      r_rd_valid   <= (w_grant0 && !req0_op) || (w_grant1 && !req1_op);
      r_rd_id      <= w_grant1;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp0_valid = r_rd_valid && !r_rd_id;
  assign rsp1_valid = r_rd_valid && r_rd_id;
  assign rsp_rdata  = mem_data_out;
  assign clear_busy = (r_state == ST_CLEAR);
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Self-checking bench for spmv_mem_arbiter: directed vector table, corner sequences, and randomized traffic vs a scoreboard.
module tb_spmv_mem_arbiter;
  localparam int WIDTH = 32;
  localparam int SIZE = 16;
  localparam int AB = $clog2(SIZE - 1);
`ifdef SPMV_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk, rst;
  logic req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [AB-1:0] req0_addr, req1_addr, mem_addr;
  logic [WIDTH-1:0] req0_wdata, req1_wdata, rsp_rdata, mem_data_in, mem_data_out;
  logic rsp0_valid, rsp1_valid, clear_req, clear_busy, clear_done, mem_data_op;

  spmv_mem_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_op(mem_data_op),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory instance model: registered read, write when op=1.
  logic [WIDTH-1:0] tb_mem [SIZE];
  always @(posedge clk) begin
    if (mem_data_op) tb_mem[mem_addr] <= mem_data_in;
    mem_data_out <= tb_mem[mem_addr];
  end

  int total = 0;
  int bad = 0;

  // Scoreboard state
  logic [WIDTH-1:0] sh [SIZE];
  int m_left;
  bit m_prio, m_done, m_rsp_v, m_rsp_id;
  logic [WIDTH-1:0] m_rsp_d;

  // Samples from the last checked cycle
  logic s_r0, s_r1, s_rsp0, s_rsp1, s_busy, s_done;
  logic [WIDTH-1:0] s_rdata;
  logic [WIDTH-1:0] fillv [SIZE];
  logic [WIDTH-1:0] got [SIZE];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_left = 0; m_prio = 1'b0; m_done = 1'b0; m_rsp_v = 1'b0; m_rsp_id = 1'b0;
  endtask

  // One clock cycle: predict, check at negedge, advance the model at posedge.
  task automatic cycle();
    logic er0, er1, eop, ebusy;
    logic [AB-1:0] ea;
    logic [WIDTH-1:0] ed;
    int win;
    er0 = 1'b0; er1 = 1'b0; eop = 1'b0; ebusy = 1'b0; ea = '0; ed = '0; win = -1;
    if (m_left > 0) begin
      ebusy = 1'b1; eop = 1'b1; ea = AB'(SIZE - m_left);
    end else if (clear_req) begin
      win = -1;
    end else if (req0_valid && req1_valid) begin
      win = FIXED ? 0 : int'(m_prio);
    end else if (req0_valid) begin
      win = 0;
    end else if (req1_valid) begin
      win = 1;
    end
    if (win == 0) begin er0 = 1'b1; eop = req0_op; ea = req0_addr; ed = req0_wdata; end
    if (win == 1) begin er1 = 1'b1; eop = req1_op; ea = req1_addr; ed = req1_wdata; end
    @(negedge clk);
    chk("req0_ready", req0_ready, er0);
    chk("req1_ready", req1_ready, er1);
    chk("mem_data_op", mem_data_op, eop);
    chk("mem_addr", mem_addr, ea);
    chk("mem_data_in", mem_data_in, ed);
    chk("clear_busy", clear_busy, ebusy);
    chk("clear_done", clear_done, m_done);
    chk("rsp0_valid", rsp0_valid, m_rsp_v && !m_rsp_id);
    chk("rsp1_valid", rsp1_valid, m_rsp_v && m_rsp_id);
    if (m_rsp_v) chk("rsp_rdata", rsp_rdata, m_rsp_d);
    s_r0 = req0_ready; s_r1 = req1_ready; s_rsp0 = rsp0_valid; s_rsp1 = rsp1_valid;
    s_busy = clear_busy; s_done = clear_done; s_rdata = rsp_rdata;
    @(posedge clk);
    m_rsp_v = 1'b0;
    if (win >= 0) begin
      if (eop) sh[ea] = ed;
      else begin m_rsp_v = 1'b1; m_rsp_id = (win == 1); m_rsp_d = sh[ea]; end
      if (req0_valid && req1_valid && !FIXED) m_prio = (win == 0);
    end
    if (m_left > 0) begin
      sh[ea] = '0; m_left--; m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (clear_req) m_left = SIZE;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; req0_op = 1'b0; req1_op = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0; clear_req = 1'b0;
  endtask

  task automatic fill_all();
    idle_inputs();
    for (int a = 0; a < SIZE; a++) begin
      fillv[a] = $urandom | 32'h1;
      req1_valid = 1'b1; req1_op = 1'b1; req1_addr = AB'(a); req1_wdata = fillv[a];
      cycle();
    end
    idle_inputs();
  endtask

  task automatic read_all();
    idle_inputs();
    for (int a = 0; a <= SIZE; a++) begin
      req0_valid = (a < SIZE); req0_op = 1'b0; req0_addr = AB'(a);
      cycle();
      if (a > 0) got[a-1] = s_rdata;
    end
    idle_inputs();
  endtask

  typedef struct packed {
    logic v0, v1, op0, op1;
    logic [AB-1:0] a0, a1;
    logic [WIDTH-1:0] d0;
    logic clr;
    logic e_r0, e_r1, e_op;
    logic [AB-1:0] e_addr;
    logic e_rsp0, e_rsp1;
  } vec_t;

  function automatic vec_t mk(input logic v0, v1, op0, op1, input logic [AB-1:0] a0, a1,
                              input logic [WIDTH-1:0] d0, input logic er0, er1, eop,
                              input logic [AB-1:0] ea, input logic ers0, ers1);
    vec_t v;
    v = '{v0, v1, op0, op1, a0, a1, d0, 1'b0, er0, er1, eop, ea, ers0, ers1};
    return v;
  endfunction

  vec_t tbl [10];
  int nb, ng;

  initial begin
    idle_inputs();
    mreset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_rsp0", rsp0_valid, 1'b0);
    chk("rst_rsp1", rsp1_valid, 1'b0);
    chk("rst_busy", clear_busy, 1'b0);
    chk("rst_done", clear_done, 1'b0);
    chk("rst_op", mem_data_op, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors: write, read-back, contention pattern
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 1, 0, 3, 0, 32'hA5,    1, 0, 1, 3, 0, 0);
    tbl[2] = mk(0, 1, 0, 0, 0, 3, 0,         0, 1, 0, 3, 0, 0);
`ifdef SPMV_MEM_ARB_FIXED_PRIO_EN
    tbl[3] = mk(1, 1, 0, 0, 3, 3, 0,         1, 0, 0, 3, 0, 1);
    for (int i = 4; i < 9; i++) tbl[i] = mk(1, 1, 0, 0, 3, 3, 0, 1, 0, 0, 3, 1, 0);
    tbl[9] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 0);
`else
    tbl[3] = mk(1, 1, 0, 0, 3, 3, 0,         1, 0, 0, 3, 0, 1);
    tbl[4] = mk(1, 1, 0, 0, 3, 3, 0,         0, 1, 0, 3, 1, 0);
    tbl[5] = mk(1, 1, 0, 0, 3, 3, 0,         1, 0, 0, 3, 0, 1);
    tbl[6] = mk(1, 1, 0, 0, 3, 3, 0,         0, 1, 0, 3, 1, 0);
    tbl[7] = mk(1, 1, 0, 0, 3, 3, 0,         1, 0, 0, 3, 0, 1);
    tbl[8] = mk(1, 1, 0, 0, 3, 3, 0,         0, 1, 0, 3, 1, 0);
    tbl[9] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 1);
`endif
    for (int i = 0; i < 10; i++) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1; req0_op = tbl[i].op0; req1_op = tbl[i].op1;
      req0_addr = tbl[i].a0; req1_addr = tbl[i].a1; req0_wdata = tbl[i].d0; req1_wdata = '0;
      clear_req = tbl[i].clr;
      cycle();
      chk($sformatf("tbl%0d_ready0", i), s_r0, tbl[i].e_r0);
      chk($sformatf("tbl%0d_ready1", i), s_r1, tbl[i].e_r1);
      chk($sformatf("tbl%0d_rsp0", i), s_rsp0, tbl[i].e_rsp0);
      chk($sformatf("tbl%0d_rsp1", i), s_rsp1, tbl[i].e_rsp1);
      if (tbl[i].e_rsp0 || tbl[i].e_rsp1) chk($sformatf("tbl%0d_rdata", i), s_rdata, 32'hA5);
    end
    idle_inputs();

    // Clear with both requesters pushing
    fill_all();
    req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = AB'(2); req1_addr = AB'(9);
    clear_req = 1'b1;
    cycle();
    chk("clr_req_cycle_grants", {s_r0, s_r1}, 2'b00);
    clear_req = 1'b0;
    nb = 0; ng = 0;
    for (int k = 1; k <= SIZE; k++) begin
      cycle();
      nb += int'(s_busy);
      ng += int'(s_r0 | s_r1);
    end
    chk("clr_busy_cycles", nb, SIZE);
    chk("clr_grants", ng, 0);
    cycle();
    chk("clr_done_pulse", s_done, 1'b1);
    chk("clr_busy_after", s_busy, 1'b0);
    idle_inputs();
    cycle();
    read_all();
    for (int a = 0; a < SIZE; a++) chk($sformatf("clr_zero_%0d", a), got[a], 32'h0);

    // Read granted at T, clear_req at T+1
    fill_all();
    req1_valid = 1'b1; req1_op = 1'b0; req1_addr = AB'(7);
    cycle();
    idle_inputs();
    clear_req = 1'b1;
    cycle();
    chk("rdclr_rsp1", s_rsp1, 1'b1);
    chk("rdclr_rdata", s_rdata, fillv[7]);
    clear_req = 1'b0;
    for (int k = 1; k <= SIZE; k++) cycle();
    cycle();
    chk("rdclr_done", s_done, 1'b1);

    // Reset in the middle of a sweep
    fill_all();
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    for (int k = 1; k <= 5; k++) cycle();
    rst = 1'b1;
    #1;
    chk("rstmid_busy", clear_busy, 1'b0);
    chk("rstmid_done", clear_done, 1'b0);
    mreset();
    @(negedge clk);
    chk("rstmid_done_hold", clear_done, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    read_all();
    for (int a = 0; a < SIZE; a++)
      chk($sformatf("rstmid_mem_%0d", a), got[a], (a < 5) ? 32'h0 : fillv[a]);

    // Randomized traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_op = 1'($urandom_range(0, 1)); req1_op = 1'($urandom_range(0, 1));
      req0_addr = AB'($urandom_range(0, SIZE - 1)); req1_addr = AB'($urandom_range(0, SIZE - 1));
      req0_wdata = $urandom; req1_wdata = $urandom;
      clear_req = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
